// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// 1-to-NUM_OUT handshaked stream demultiplexer. Each accepted input word goes
// into the FIFO of the channel named by in_sel. Words whose in_sel is
// NUM_OUT or higher are consumed and dropped, and a saturating counter counts
// them. While a channel is idle its data bus is driven to zero.
//
// Handshake rules (valid/ready):
//   A word is transferred on a rising clk edge when valid and ready are both
//   high. Ready never depends on valid. Once a producer raises valid it may
//   drop it again before any transfer on the input side. On each output side,
//   out_valid[k] stays high and out_data[k] stays stable until that channel
//   transfers. The input side is the exception: in_valid may fall without a
//   transfer.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   in_data      input word
//   in_sel       destination channel; in_sel >= NUM_OUT means drop
//   in_valid     in_data/in_sel valid
//   in_ready     block can accept this cycle (comb from in_sel and FIFO state)
//   flush        synchronous clear of all FIFOs
//   out_data     channel k at bits [k*DATA_W +: DATA_W], zero when not valid
//   out_valid    per-channel valid (FIFO not empty)
//   out_ready    per-channel downstream ready
//   drop_cnt     saturating count of dropped words
//   overflow_err sticky, set if a push ever targets a full FIFO
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter int  DATA_W     = 16,
    parameter int  NUM_OUT    = 3,
    parameter int  FIFO_DEPTH = 2,
    parameter int  CNT_W      = 8,
    localparam int SEL_W      = $clog2(NUM_OUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      overflow_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem    [NUM_OUT][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NUM_OUT];
    logic [PTR_W-1:0]  wr_ptr [NUM_OUT];
    logic [OCC_W-1:0]  occ    [NUM_OUT];

    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] empty;
    logic [NUM_OUT-1:0] push;
    logic [NUM_OUT-1:0] pop;
    logic               sel_in_range;
    logic               sel_full;
    logic               accept;
    logic               drop;

    always_comb begin
        full         = '0;
        empty        = '0;
        push         = '0;
        pop          = '0;
        out_valid    = '0;
        out_data     = '0;
        sel_full     = 1'b0;
        sel_in_range = (in_sel < SEL_W'(NUM_OUT));

        for (int k = 0; k < NUM_OUT; k++) begin
            full[k]  = (occ[k] == OCC_W'(FIFO_DEPTH));
            empty[k] = (occ[k] == '0);
            // Fullness of the addressed channel only; out-of-range selects
            // never match, so they see no backpressure.
            if (in_sel == SEL_W'(k)) begin
                sel_full = full[k];
            end
        end

        // No full-bypass: a pop in the same cycle does not make room.
        in_ready = rst_n & ~flush & (~sel_in_range | ~sel_full);
        accept   = in_valid & in_ready;
        drop     = accept & ~sel_in_range;

        for (int k = 0; k < NUM_OUT; k++) begin
            push[k]      = accept & (in_sel == SEL_W'(k));
            pop[k]       = ~empty[k] & out_ready[k];
            out_valid[k] = ~empty[k];
            if (!empty[k]) begin
                out_data[k*DATA_W +: DATA_W] = mem[k][rd_ptr[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                occ[k]    <= '0;
            end
            drop_cnt     <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            // Handshakes in a flush cycle are ignored. Counters are kept.
            for (int k = 0; k < NUM_OUT; k++) begin
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                occ[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= in_data;
                    wr_ptr[k]         <= wr_ptr[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                if (push[k] && !pop[k]) begin
                    occ[k] <= occ[k] + OCC_W'(1);
                end else if (pop[k] && !push[k]) begin
                    occ[k] <= occ[k] - OCC_W'(1);
                end
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            // Guard against a broken ready path ever letting a push through.
            if (|(push & full)) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

    localparam int DATA_W     = 16;
    localparam int NUM_OUT    = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 8;
    localparam int SEL_W      = 2;
    localparam int DROP_MAX   = 255;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [DATA_W-1:0]         in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_valid;
    logic                      in_ready;
    logic                      flush;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_ready;
    logic [CNT_W-1:0]          drop_cnt;
    logic                      overflow_err;

    // Reference model: one queue per channel plus a drop count.
    logic [DATA_W-1:0] mq [NUM_OUT][$];
    int                m_drop;

    int n_cmp;
    int n_err;

    always #5 clk = ~clk;

    stream_demux #(
        .DATA_W    (DATA_W),
        .NUM_OUT   (NUM_OUT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .drop_cnt    (drop_cnt),
        .overflow_err(overflow_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks outputs against the model, then advances one clock edge and
    // applies the same edge to the model.
    task automatic cycle();
        logic [NUM_OUT*DATA_W-1:0] e_data;
        logic [NUM_OUT-1:0]        e_valid;
        logic                      e_ready;
        #1;
        e_data  = '0;
        e_valid = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (mq[k].size() > 0) begin
                e_valid[k]               = 1'b1;
                e_data[k*DATA_W +: DATA_W] = mq[k][0];
            end
        end
        if (!rst_n || flush)                  e_ready = 1'b0;
        else if (int'(in_sel) >= NUM_OUT)     e_ready = 1'b1;
        else                                  e_ready = (mq[int'(in_sel)].size() < FIFO_DEPTH);

        check("in_ready",     64'(in_ready),     64'(e_ready));
        check("out_valid",    64'(out_valid),    64'(e_valid));
        check("out_data",     64'(out_data),     64'(e_data));
        check("drop_cnt",     64'(drop_cnt),     64'(m_drop));
        check("overflow_err", 64'(overflow_err), 64'(0));

        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) mq[k].delete();
            m_drop = 0;
        end else if (flush) begin
            for (int k = 0; k < NUM_OUT; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (mq[k].size() > 0 && out_ready[k]) void'(mq[k].pop_front());
            end
            if (in_valid && e_ready) begin
                if (int'(in_sel) < NUM_OUT) mq[int'(in_sel)].push_back(in_data);
                else if (m_drop < DROP_MAX)  m_drop++;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        m_drop    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, reset still held
        idle(1);
        rst_n = 1'b1;

        // One word per channel, all downstream ready
        out_ready = 3'b111;
        drive(1'b1, 2'd0, 16'h1111);
        drive(1'b1, 2'd1, 16'h2222);
        drive(1'b1, 2'd2, 16'h3333);
        idle(3);

        // Backpressure on channel 1; channel 0 keeps flowing
        out_ready = 3'b101;
        drive(1'b1, 2'd1, 16'hA001);
        drive(1'b1, 2'd1, 16'hA002);
        drive(1'b1, 2'd1, 16'hA003);
        drive(1'b1, 2'd0, 16'h0B01);
        drive(1'b1, 2'd1, 16'hA003);
        out_ready = 3'b111;
        drive(1'b1, 2'd1, 16'hA003);
        drive(1'b1, 2'd1, 16'hA003);
        idle(4);

        // Drop path saturates at 255
        for (int i = 0; i < 260; i++) drive(1'b1, 2'd3, 16'($urandom));
        idle(2);

        // Full channel 2 with a same-cycle pop: no bypass
        out_ready = 3'b011;
        drive(1'b1, 2'd2, 16'hC001);
        drive(1'b1, 2'd2, 16'hC002);
        out_ready = 3'b111;
        drive(1'b1, 2'd2, 16'hC003);
        drive(1'b1, 2'd2, 16'hC003);
        idle(3);

        // Flush with traffic pending and a word offered
        out_ready = 3'b000;
        drive(1'b1, 2'd0, 16'hD001);
        drive(1'b1, 2'd0, 16'hD002);
        drive(1'b1, 2'd2, 16'hD003);
        flush = 1'b1;
        drive(1'b1, 2'd1, 16'hD004);
        flush = 1'b0;
        idle(1);
        out_ready = 3'b111;
        idle(2);

        // Reset with words on every channel
        out_ready = 3'b000;
        drive(1'b1, 2'd0, 16'hE001);
        drive(1'b1, 2'd1, 16'hE002);
        drive(1'b1, 2'd2, 16'hE003);
        rst_n = 1'b0;
        drive(1'b1, 2'd0, 16'hE004);
        rst_n = 1'b1;
        out_ready = 3'b111;
        drive(1'b1, 2'd1, 16'hE005);
        drive(1'b1, 2'd3, 16'hE006);
        drive(1'b1, 2'd3, 16'hE007);
        // Flush preserves a non-saturated drop count
        flush = 1'b1;
        drive(1'b1, 2'd3, 16'hE008);
        flush = 1'b0;
        idle(3);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            out_ready = 3'($urandom);
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 16'($urandom));
        end
        rst_n     = 1'b1;
        flush     = 1'b0;
        out_ready = 3'b111;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
